// File: rtl/ddr_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg : shared types for the DDR command arbiter and its read tag FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ddr_arb_pkg;

  localparam int CNT_W      = 32;
  // Struct fields are sized for the widest supported configuration.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_LEN_W  = 16;
  localparam int ID_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_LEN_W-1:0]  len;
  } ddr_cmd_t;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [MAX_LEN_W-1:0] len;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/rd_tag_fifo.sv
// ----------------------------------------------------------------------------
// rd_tag_fifo : synchronous FIFO of read tags, push and pop allowed together
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rd_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_push,
  input  rd_tag_t i_push_data,
  input  logic    i_pop,
  output rd_tag_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  rd_tag_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push_en;
  logic            w_pop_en;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_en  = i_pop & ~o_empty;
  assign w_push_en = i_push & (~o_full | w_pop_en);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_cmd_arbiter : round-robin DDR command arbiter, write routing, in-order reads
// Option DDR_ARB_PERF_CNT_EN adds per-requester grant counters.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ddr_cmd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int DATA_W    = 512,
  parameter int TAG_DEPTH = 16
) (
  input  logic                      core_clk,
  input  logic                      sys_rst_n,
  input  logic                      init_calib_complete,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ-1:0]        wdata_valid,
  output logic [NUM_REQ-1:0]        wdata_ready,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        rdata_valid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_wr,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [LEN_W-1:0]          cmd_len,
  output logic                      mem_wdata_valid,
  input  logic                      mem_wdata_ready,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_rdata_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic                      rd_err,
  output logic [NUM_REQ*CNT_W-1:0]  perf_grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             r_state;
  ddr_cmd_t               r_cmd;
  logic                   r_cmd_valid;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [LEN_W-1:0]       r_beat;
  logic [LEN_W-1:0]       r_head_cnt;
  logic [NUM_REQ-1:0]     r_rdata_valid;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rd_err;

  logic [ADDR_W-1:0]      w_addr_a  [NUM_REQ];
  logic [LEN_W-1:0]       w_len_a   [NUM_REQ];
  logic [DATA_W-1:0]      w_wdata_a [NUM_REQ];
  logic [NUM_REQ-1:0]     w_elig;
  logic [2*NUM_REQ-1:0]   w_rot_dbl;
  logic                   w_found;
  logic [IDX_W:0]         w_sum;
  logic [IDX_W-1:0]       w_pick;
  logic [IDX_W-1:0]       w_next_ptr;
  logic                   w_cmd_hs;
  logic                   w_in_wdata;
  logic                   w_wbeat;
  logic [NUM_REQ-1:0]     w_req_ready;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_last;
  rd_tag_t                w_push_tag;
  rd_tag_t                w_head;
  logic [NUM_REQ-1:0]     w_head_oh;
  logic                   w_unused;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_a[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_len_a[gi]   = req_len[gi*LEN_W +: LEN_W];
    assign w_wdata_a[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // Reads are only eligible while a tag slot is free to track their return.
  assign w_elig    = req_valid & (req_wr | {NUM_REQ{~w_full}});
  assign w_rot_dbl = {w_elig, w_elig} >> r_rr_ptr;

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot_dbl[i]) begin
        w_found = 1'b1;
        w_sum   = (IDX_W+1)'(i) + {1'b0, r_rr_ptr};
      end
    end
    w_pick = (w_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                                            : IDX_W'(w_sum);
  end

  assign w_next_ptr = (w_pick == IDX_W'(NUM_REQ-1)) ? '0 : w_pick + 1'b1;
  assign w_cmd_hs   = r_cmd_valid & cmd_ready;
  assign w_in_wdata = (r_state == WDATA);
  assign w_wbeat    = mem_wdata_valid & mem_wdata_ready;

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (init_calib_complete && w_found) begin
            r_cmd.wr    <= req_wr[w_pick];
            r_cmd.addr  <= MAX_ADDR_W'(w_addr_a[w_pick]);
            r_cmd.len   <= MAX_LEN_W'(w_len_a[w_pick]);
            r_cmd_valid <= 1'b1;
            r_grant     <= w_pick;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= CMD;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            if (r_cmd.wr) begin
              r_beat  <= r_cmd.len[LEN_W-1:0];
              r_state <= WDATA;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        WDATA: begin
          if (w_wbeat) begin
            if (r_beat == '0) r_state <= IDLE;
            else              r_beat  <= r_beat - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_req_ready = '0;
    wdata_ready = '0;
    if (w_cmd_hs)   w_req_ready[r_grant] = 1'b1;
    if (w_in_wdata) wdata_ready[r_grant] = mem_wdata_ready;
  end

  assign req_ready       = w_req_ready;
  assign mem_wdata_valid = w_in_wdata & wdata_valid[r_grant];
  assign mem_wdata       = w_in_wdata ? w_wdata_a[r_grant] : '0;
  assign cmd_valid       = r_cmd_valid;
  assign cmd_wr          = r_cmd.wr;
  assign cmd_addr        = r_cmd.addr[ADDR_W-1:0];
  assign cmd_len         = r_cmd.len[LEN_W-1:0];

  assign w_push     = w_cmd_hs & ~r_cmd.wr;
  assign w_push_tag = '{id: ID_W'(r_grant), len: r_cmd.len};
  assign w_last     = (MAX_LEN_W'(r_head_cnt) == w_head.len);
  assign w_pop      = mem_rdata_valid & ~w_empty & w_last;

  rd_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk         (core_clk),
    .rst_n       (sys_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_tag),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_head_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) w_head_oh[i] = (w_head.id == ID_W'(i));
  end

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rdata_valid <= '0;
      r_rdata       <= '0;
      r_head_cnt    <= '0;
      r_rd_err      <= 1'b0;
    end else begin
      r_rdata_valid <= '0;
      if (mem_rdata_valid) begin
        if (w_empty) begin
          r_rd_err <= 1'b1;
        end else begin
          r_rdata_valid <= w_head_oh;
          r_rdata       <= mem_rdata;
          r_head_cnt    <= w_last ? '0 : r_head_cnt + 1'b1;
        end
      end
    end
  end

  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rd_err      = r_rd_err;
  assign busy        = (r_state != IDLE) | ~w_empty;
  assign w_unused    = ^{r_cmd.addr, r_cmd.len, w_rot_dbl};

`ifdef DDR_ARB_PERF_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge core_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)          r_cnt <= '0;
      else if (w_req_ready[gi]) r_cnt <= r_cnt + 1'b1;
    end
    assign perf_grant_cnt[gi*CNT_W +: CNT_W] = r_cnt;
  end
`else
  assign perf_grant_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_cmd_arbiter : directed self-checking bench for ddr_cmd_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ddr_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 64;
  localparam int TD = 16;

  logic            core_clk = 1'b0;
  logic            sys_rst_n;
  logic            init_calib_complete;
  logic [N-1:0]    req_valid, req_ready, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    wdata_valid, wdata_ready, rdata_valid;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata;
  logic            cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic            mem_wdata_valid, mem_wdata_ready;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rdata_valid;
  logic [DW-1:0]   mem_rdata;
  logic            busy, rd_err;
  logic [N*32-1:0] perf_grant_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ddr_cmd_arbiter #(
    .NUM_REQ (N), .ADDR_W (AW), .LEN_W (LW), .DATA_W (DW), .TAG_DEPTH (TD)
  ) dut (
    .core_clk            (core_clk),
    .sys_rst_n           (sys_rst_n),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_wr              (req_wr),
    .req_addr            (req_addr),
    .req_len             (req_len),
    .wdata_valid         (wdata_valid),
    .wdata_ready         (wdata_ready),
    .wdata               (wdata),
    .rdata_valid         (rdata_valid),
    .rdata               (rdata),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_wr              (cmd_wr),
    .cmd_addr            (cmd_addr),
    .cmd_len             (cmd_len),
    .mem_wdata_valid     (mem_wdata_valid),
    .mem_wdata_ready     (mem_wdata_ready),
    .mem_wdata           (mem_wdata),
    .mem_rdata_valid     (mem_rdata_valid),
    .mem_rdata           (mem_rdata),
    .busy                (busy),
    .rd_err              (rd_err),
    .perf_grant_cnt      (perf_grant_cnt)
  );

  always #5 core_clk = ~core_clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #2;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  // Presents one command on lane idx, checks the cmd fields at the handshake.
  task automatic issue(input int idx, input logic wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] len);
    logic got;
    got = 1'b0;
    req_wr[idx]            = wr;
    req_addr[idx*AW +: AW] = addr;
    req_len[idx*LW +: LW]  = len;
    req_valid[idx]         = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_ready[idx]) begin
        got = 1'b1;
        check_val("issue_wr", cmd_wr, wr);
        check_val("issue_addr", cmd_addr, addr);
        check_val("issue_len", cmd_len, len);
      end
      tick();
    end
    req_valid[idx] = 1'b0;
    check_val($sformatf("issue_grant%0d", idx), got, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt, k, beats, bad, r0, r1;
    logic        got, hs_d;
    logic [3:0]  exp_oh;
    logic [31:0] exp_perf;

    req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0;
    wdata_valid = '0; wdata = '0; cmd_ready = 1'b1; mem_wdata_ready = 1'b1;
    mem_rdata_valid = 1'b0; mem_rdata = '0; init_calib_complete = 1'b0;
    sys_rst_n = 1'b0;
    tick();
    tick();

    check_val("rst_cmd_valid", cmd_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_rd_err", rd_err, 1'b0);
    check_val("rst_req_ready", req_ready, 4'h0);
    check_val("rst_rdata_valid", rdata_valid, 4'h0);
    check_val("rst_perf", perf_grant_cnt, '0);
    sys_rst_n = 1'b1;
    tick();

    // Calibration gating, then release.
    req_addr[0 +: AW] = 32'h0000_1000;
    req_valid = 4'b0001;
    cnt = 0;
    repeat (100) begin
      tick();
      if (cmd_valid) cnt++;
    end
    check_val("calib_gate", cnt, 0);
    init_calib_complete = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      tick();
      if (cmd_valid) got = 1'b1;
    end
    check_val("calib_release", got, 1'b1);
    check_val("calib_addr", cmd_addr, 32'h0000_1000);
    check_val("calib_req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    mem_rdata_valid = 1'b1;
    mem_rdata = 64'h1111;
    tick();
    mem_rdata_valid = 1'b0;
    check_val("calib_rd_valid", rdata_valid, 4'b0001);
    check_val("calib_rdata", rdata, 64'h1111);
    tick();
    check_val("calib_rd_valid_off", rdata_valid, 4'b0000);
    check_val("calib_busy", busy, 1'b0);

    // Round robin over four continuous readers, one return beat per grant.
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h100 * i;
    req_len = '0; req_wr = '0; req_valid = 4'b1111;
    k = 0; hs_d = 1'b0;
    for (int c = 0; c < 200 && k < 20; c++) begin
      mem_rdata_valid = hs_d;
      #1;
      hs_d = (req_ready != 0);
      if (hs_d) begin
        exp_oh = 4'b0001 << (k % 4);
        check_val("rr_order", req_ready, exp_oh);
        k++;
      end
      tick();
    end
    req_valid = '0;
    mem_rdata_valid = hs_d;
    tick();
    mem_rdata_valid = 1'b0;
    tick();
    check_val("rr_count", k, 20);
    check_val("rr_busy", busy, 1'b0);
    check_val("rr_rd_err", rd_err, 1'b0);
`ifdef DDR_ARB_PERF_CNT_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    for (int i = 0; i < N; i++)
      check_val($sformatf("perf%0d", i), perf_grant_cnt[i*32 +: 32], exp_perf);

    // Write routing from requester 2, ready toggling.
    wdata_valid = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*DW +: DW] = 64'hDEAD_0000 + i;
    wdata[2*DW +: DW] = 64'hA0;
    issue(2, 1'b1, 32'h2000, 8'd3);
    beats = 0; bad = 0;
    for (int c = 0; c < 30 && beats < 4; c++) begin
      mem_wdata_ready = (c % 2 == 0);
      #1;
      if ((wdata_ready & 4'b1011) != 0) bad++;
      if (mem_wdata_valid && mem_wdata_ready) begin
        check_val("wr_beat_data", mem_wdata, 64'hA0 + beats);
        beats++;
      end
      tick();
      wdata[2*DW +: DW] = 64'hA0 + beats;
    end
    mem_wdata_ready = 1'b1;
    #1;
    check_val("wr_beats", beats, 4);
    check_val("wr_other_ready", bad, 0);
    check_val("wr_idle_busy", busy, 1'b0);
    check_val("wr_idle_valid", mem_wdata_valid, 1'b0);
    check_val("wr_idle_ready", wdata_ready, 4'b0000);

    // In-order read return: req 1 len 1, then req 3 len 0.
    issue(1, 1'b0, 32'h3000, 8'd1);
    issue(3, 1'b0, 32'h3100, 8'd0);
    mem_rdata_valid = 1'b1; mem_rdata = 64'hD1;
    tick();
    mem_rdata = 64'hD2;
    check_val("ord_v0", rdata_valid, 4'b0010);
    check_val("ord_d0", rdata, 64'hD1);
    tick();
    mem_rdata = 64'hD3;
    check_val("ord_v1", rdata_valid, 4'b0010);
    check_val("ord_d1", rdata, 64'hD2);
    tick();
    mem_rdata_valid = 1'b0;
    check_val("ord_v2", rdata_valid, 4'b1000);
    check_val("ord_d2", rdata, 64'hD3);
    tick();
    check_val("ord_v3", rdata_valid, 4'b0000);
    check_val("ord_busy", busy, 1'b0);

    // Tag FIFO full: reads blocked, writes still granted.
    for (int i = 0; i < TD; i++) issue(0, 1'b0, 32'h4000 + 32'(i * 64), 8'd0);
    req_wr[0] = 1'b0; req_len[0 +: LW] = 8'd0; req_valid[0] = 1'b1;
    req_wr[1] = 1'b1; req_len[LW +: LW] = 8'd0; req_addr[AW +: AW] = 32'h4800;
    req_valid[1] = 1'b1;
    r0 = 0; r1 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready[0]) r0++;
      if (req_ready[1]) r1++;
      tick();
      if (r1 != 0) req_valid[1] = 1'b0;
    end
    check_val("full_rd_blocked", r0, 0);
    check_val("full_wr_granted", r1, 1);
    check_val("full_busy", busy, 1'b1);
    mem_rdata_valid = 1'b1; mem_rdata = 64'hE0;
    tick();
    mem_rdata_valid = 1'b0;
    check_val("full_ret_valid", rdata_valid, 4'b0001);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (req_ready[0]) got = 1'b1;
      tick();
    end
    req_valid[0] = 1'b0;
    check_val("full_rd_after_free", got, 1'b1);
    mem_rdata_valid = 1'b1;
    repeat (TD) tick();
    mem_rdata_valid = 1'b0;
    tick();
    check_val("full_drain_busy", busy, 1'b0);
    check_val("full_drain_err", rd_err, 1'b0);

    // Stray read beat with nothing outstanding.
    mem_rdata_valid = 1'b1; mem_rdata = 64'hBAD;
    tick();
    mem_rdata_valid = 1'b0;
    check_val("err_set", rd_err, 1'b1);
    check_val("err_dropped", rdata_valid, 4'b0000);
    repeat (3) tick();
    check_val("err_sticky", rd_err, 1'b1);

    // Reset in the middle of a stalled write burst.
    mem_wdata_ready = 1'b0;
    issue(2, 1'b1, 32'h5000, 8'd7);
    #1;
    check_val("mid_busy", busy, 1'b1);
    check_val("mid_wvalid", mem_wdata_valid, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check_val("arst_cmd_valid", cmd_valid, 1'b0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_rd_err", rd_err, 1'b0);
    check_val("arst_wvalid", mem_wdata_valid, 1'b0);
    check_val("arst_wdata", mem_wdata, 64'h0);
    check_val("arst_wready", wdata_ready, 4'b0000);
    check_val("arst_req_ready", req_ready, 4'b0000);
    check_val("arst_perf", perf_grant_cnt, '0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    check_val("arst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Shares one DDR4 channel application port between NUM_REQ on-chip requesters (layer load/store engines) inside fpga_top; one instance per channel (c0, c1).
- Round-robin arbitration of read/write burst commands, gated by init_calib_complete.
- Routes write data from the granted writer; returns read data in order using a tag FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, byte address width
- LEN_W, 8, burst length field width; value = beats-1
- DATA_W, 512, data beat width
- TAG_DEPTH, 16, outstanding read commands tracked (power of 2)

Ports:
- core_clk  in  1  clock
- sys_rst_n  in  1  async reset, active low
- init_calib_complete  in  1  DDR calibration done
- req_valid  in  NUM_REQ  command request per requester
- req_ready  out  NUM_REQ  command accepted (one-hot pulse)
- req_wr  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  burst start address
- req_len  in  NUM_REQ*LEN_W  beats-1
- wdata_valid  in  NUM_REQ  write beat valid
- wdata_ready  out  NUM_REQ  write beat accepted
- wdata  in  NUM_REQ*DATA_W  write beats
- rdata_valid  out  NUM_REQ  one-hot read beat strobe
- rdata  out  DATA_W  read beat, broadcast
- cmd_valid, cmd_ready  out, in  1  command handshake to DDR side
- cmd_wr  out  1; cmd_addr  out  ADDR_W; cmd_len  out  LEN_W
- mem_wdata_valid, mem_wdata_ready  out, in  1; mem_wdata  out  DATA_W
- mem_rdata_valid  in  1; mem_rdata  in  DATA_W (no backpressure)
- busy  out  1  FSM not IDLE or tags outstanding
- rd_err  out  1  sticky: read beat arrived with tag FIFO empty
- perf_grant_cnt  out  NUM_REQ*32  grant counters (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; RR pointer = 0; tag FIFO empty; rd_err = 0.
- Reset asserted mid-burst aborts immediately; DDR side is reset by the same sys_rst_n.
- Requester rule: req_* fields held stable while req_valid=1 until req_ready.
- FSM IDLE:
  - Eligible requesters: req_valid=1 and (req_wr=1 or tag FIFO not full).
  - If init_calib_complete=1 and any requester is eligible, choose the first eligible at or after the RR pointer.
  - Register cmd_* and the grant index; advance RR pointer to grant+1 mod NUM_REQ; go to CMD.
- FSM CMD:
  - cmd_valid=1 and cmd_* stable until cmd_ready.
  - On handshake, pulse req_ready[grant] for one cycle, the same cycle.
  - Write: load beat counter = cmd_len, go to WDATA.
  - Read: push grant index and cmd_len into tag FIFO, go to IDLE.
- FSM WDATA:
  - Combinational pass-through: mem_wdata_valid = wdata_valid[grant], wdata_ready[grant] = mem_wdata_ready, mem_wdata = wdata[grant]. Other wdata_ready lanes are 0.
  - Decrement counter on each accepted beat; the beat accepted at counter 0 returns to IDLE.
- Minimum gap: 1 idle cycle between commands (IDLE→CMD).
- Read return, 1-cycle registered latency:
  - Each mem_rdata_valid beat produces rdata_valid[head.id] and rdata on the next cycle.
  - Head beat counter counts head.len+1 beats, then pops the FIFO.
  - Push and pop in the same cycle are allowed.
  - Beat arriving with FIFO empty: set rd_err, drop the beat.
- init_calib_complete falling: only gates new grants; commands and bursts in flight complete.

Optional Feature:
- Macro: DDR_ARB_PERF_CNT_EN.
- Defined: perf_grant_cnt[i] increments on each req_ready[i] pulse; 32-bit wrap; cleared by reset.
- Undefined: perf_grant_cnt tied to 0 and no counter logic. Port list is identical in both builds.

Decomposition:
- Package ddr_arb_pkg:
  - arb_state_e enum {IDLE, CMD, WDATA}
  - ddr_cmd_t struct {wr, addr, len}
  - rd_tag_t struct {id, len}
  - parameter-independent localparam CNT_W = 32
- Sub-module rd_tag_fifo: synchronous FIFO of rd_tag_t, depth TAG_DEPTH, with full/empty flags and push/pop in the same cycle.

Test Plan:
- Calib gating: init_calib_complete=0, req_valid=4'b0001 → cmd_valid stays 0 for 100 cycles. Raise calib → cmd_valid within 2 cycles, cmd_addr = req_addr[0].
- Round robin: all 4 requesters issue reads continuously, cmd_ready=1 → grant order 0,1,2,3,0,1… Each perf_grant_cnt = 5 after 20 grants (macro on).
- Write routing: req 2 writes len=3, mem_wdata_ready toggling 1,0 → exactly 4 beats forwarded from wdata[2]; wdata_ready[0,1,3] = 0; FSM back to IDLE.
- In-order read return: req 1 reads len=1, then req 3 reads len=0; 3 mem_rdata beats → rdata_valid = 0010, 0010, 1000; busy drops afterward.
- Tag full: 16 outstanding reads with no return → 17th read not granted while a write from another requester is still granted. One full return frees a slot → read granted.
- Error/reset: mem_rdata_valid with FIFO empty → rd_err = 1 and sticky. sys_rst_n low mid-WDATA → all outputs 0 and FSM in IDLE.
